// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DRAIN} fetch_state_t;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
    localparam int          PC_STEP   = 4;
endpackage

// File: rtl/fetch_buffer.sv
// One-entry instruction/PC holding register toward decode.
// Latency: a load shows on valid the following cycle.
// Backpressure: the entry is held until consumed; flush beats load beats consume.
module fetch_buffer
    import fetch_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int INSTR_W = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic               consume,
    input  logic               flush,
    input  logic [INSTR_W-1:0] load_instr,
    input  logic [WIDTH-1:0]   load_pc,
    output logic               valid,
    output logic [INSTR_W-1:0] instr,
    output logic [WIDTH-1:0]   pc
);

    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= 1'b0;
            instr <= INSTR_W'(NOP_INSTR);
            pc    <= '0;
        end else if (flush) begin
            valid <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
            instr <= load_instr;
            pc    <= load_pc;
        end else if (consume) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/fetch_sequencer.sv
// PC selection and single-outstanding instruction-memory fetch for the RV32I core.
// Latency: request 1 cycle after reset; response reaches decode 1 cycle after rvalid.
// Backpressure: no request while the buffer is full and stalled; redirect drains wrong-path data.
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter int               WIDTH    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = '0,
    parameter int               INSTR_W  = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stall_i,
    input  logic               redirect_i,
    input  logic [WIDTH-1:0]   redirect_target_i,
    output logic               imem_req_o,
    output logic [WIDTH-1:0]   imem_addr_o,
    input  logic               imem_gnt_i,
    input  logic               imem_rvalid_i,
    input  logic [INSTR_W-1:0] imem_rdata_i,
    output logic               instr_valid_o,
    output logic [INSTR_W-1:0] instr_o,
    output logic [WIDTH-1:0]   instr_pc_o,
    output logic               flush_o
);

    fetch_state_t     state;
    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] redirect_pc;
    logic             buf_load;
    logic             buf_consume;

    assign redirect_pc = {redirect_target_i[WIDTH-1:2], 2'b00};
    assign imem_addr_o = pc;
    assign flush_o     = redirect_i;

    // Requesting only when the buffer will have room keeps the single entry from being overwritten.
    assign imem_req_o  = (state == ISSUE) && (!instr_valid_o || !stall_i);
    assign buf_load    = (state == WAIT) && imem_rvalid_i && !redirect_i;
    assign buf_consume = instr_valid_o && !stall_i;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            pc    <= RESET_PC;
        end else begin
            if (redirect_i) begin
                pc <= redirect_pc;
            end else if (buf_load) begin
                pc <= pc + WIDTH'(PC_STEP);
            end

            case (state)
                IDLE:  state <= ISSUE;
                ISSUE: if (imem_req_o && imem_gnt_i) state <= redirect_i ? DRAIN : WAIT;
                WAIT: begin
                    if (imem_rvalid_i)   state <= ISSUE;
                    else if (redirect_i) state <= DRAIN;
                end
                DRAIN: if (imem_rvalid_i) state <= ISSUE;
                default: state <= IDLE;
            endcase
        end
    end

    fetch_buffer #(
        .WIDTH   (WIDTH),
        .INSTR_W (INSTR_W)
    ) u_buffer (
        .clk        (clk),
        .rst        (rst),
        .load       (buf_load),
        .consume    (buf_consume),
        .flush      (redirect_i),
        .load_instr (imem_rdata_i),
        .load_pc    (pc),
        .valid      (instr_valid_o),
        .instr      (instr_o),
        .pc         (instr_pc_o)
    );

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: directed protocol scenarios, then randomized memory/stall/redirect traffic.
// Outputs are compared every cycle against a transaction-level model of the fetch stage.
// Memory grants and responds with random latency; only granted requests ever get a response.
module tb_fetch_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall_i = 1'b0;
    logic        redirect_i = 1'b0;
    logic [31:0] redirect_target_i = '0;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i = 1'b0;
    logic        imem_rvalid_i = 1'b0;
    logic [31:0] imem_rdata_i = '0;
    logic        instr_valid_o;
    logic [31:0] instr_o;
    logic [31:0] instr_pc_o;
    logic        flush_o;

    always #5 clk = ~clk;

    fetch_sequencer #(
        .WIDTH    (32),
        .RESET_PC (32'h0000_0000),
        .INSTR_W  (32)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .stall_i           (stall_i),
        .redirect_i        (redirect_i),
        .redirect_target_i (redirect_target_i),
        .imem_req_o        (imem_req_o),
        .imem_addr_o       (imem_addr_o),
        .imem_gnt_i        (imem_gnt_i),
        .imem_rvalid_i     (imem_rvalid_i),
        .imem_rdata_i      (imem_rdata_i),
        .instr_valid_o     (instr_valid_o),
        .instr_o           (instr_o),
        .instr_pc_o        (instr_pc_o),
        .flush_o           (flush_o)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: what has been fetched, what is in flight, what decode sees.
    bit          m_known = 0;
    bit          m_started;
    bit          m_inflight;
    bit          m_discard;
    bit          m_bvld;
    logic [31:0] m_binstr;
    logic [31:0] m_bpc;
    logic [31:0] m_pc;
    bit          e_req;

    logic        s_req, s_vld, s_flush;
    logic [31:0] s_addr, s_instr, s_ipc;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
        end
    endtask

    task automatic step(input logic s, input logic r, input logic [31:0] tgt,
                        input logic g, input logic rv, input logic [31:0] rd,
                        input logic rs);
        bit load;
        @(negedge clk);
        rst = rs; stall_i = s; redirect_i = r; redirect_target_i = tgt;
        imem_gnt_i = g; imem_rvalid_i = rv; imem_rdata_i = rd;
        #1;
        s_req = imem_req_o; s_addr = imem_addr_o; s_vld = instr_valid_o;
        s_instr = instr_o; s_ipc = instr_pc_o; s_flush = flush_o;
        e_req = m_started && !m_inflight && (!m_bvld || !s);
        if (m_known) begin
            chk("req", {31'd0, s_req}, {31'd0, e_req});
            chk("addr", s_addr, m_pc);
            chk("instr_valid", {31'd0, s_vld}, {31'd0, m_bvld});
            chk("instr", s_instr, m_binstr);
            chk("instr_pc", s_ipc, m_bpc);
            chk("flush", {31'd0, s_flush}, {31'd0, r});
            if (rv && !rs) chk("rvalid_outstanding", {31'd0, m_inflight}, 32'd1);
        end
        if (rs) begin
            m_known = 1; m_started = 0; m_inflight = 0; m_discard = 0;
            m_bvld = 0; m_binstr = 32'h0000_0013; m_bpc = 0; m_pc = 0;
        end else begin
            load = m_inflight && !m_discard && rv && !r;
            if (r)                   m_bvld = 0;
            else if (load)           begin m_bvld = 1; m_binstr = rd; m_bpc = m_pc; end
            else if (m_bvld && !s)   m_bvld = 0;
            if (m_inflight) begin
                if (rv)      begin m_inflight = 0; m_discard = 0; end
                else if (r)  m_discard = 1;
            end else if (e_req && g) begin
                m_inflight = 1; m_discard = r;
            end
            if (r)         m_pc = tgt & 32'hFFFF_FFFC;
            else if (load) m_pc = m_pc + 32'd4;
            m_started = 1;
        end
    endtask

    bit          mem_pend;
    int          mem_cnt;

    initial begin
        step(0, 0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0, 1);
        chk("rst_req", {31'd0, s_req}, 32'd0);
        chk("rst_valid", {31'd0, s_vld}, 32'd0);
        chk("rst_instr", s_instr, 32'h0000_0013);
        chk("rst_ipc", s_ipc, 32'h0);
        step(0, 0, 0, 0, 0, 0, 0);
        chk("idle_req", {31'd0, s_req}, 32'd0);

        for (int k = 0; k < 3; k++) begin
            step(0, 0, 0, 1, 0, 0, 0);
            chk("seq_req", {31'd0, s_req}, 32'd1);
            chk("seq_addr", s_addr, 32'(4 * k));
            if (k > 0) begin
                chk("seq_valid", {31'd0, s_vld}, 32'd1);
                chk("seq_ipc", s_ipc, 32'(4 * (k - 1)));
                chk("seq_instr", s_instr, 32'h0010_0093);
            end
            step(0, 0, 0, 0, 1, 32'h0010_0093, 0);
            chk("wait_valid", {31'd0, s_vld}, 32'd0);
        end

        for (int k = 0; k < 3; k++) begin
            step(1, 0, 0, 0, 0, 0, 0);
            chk("stall_req", {31'd0, s_req}, 32'd0);
            chk("stall_ipc", s_ipc, 32'h8);
            chk("stall_instr", s_instr, 32'h0010_0093);
        end
        step(0, 0, 0, 1, 0, 0, 0);
        chk("unstall_req", {31'd0, s_req}, 32'd1);
        chk("unstall_addr", s_addr, 32'hC);
        step(0, 0, 0, 0, 1, 32'h1357_9BDF, 0);

        for (int k = 0; k < 3; k++) begin
            step(0, 0, 0, (k == 2), 0, 0, 0);
            chk("hold_req", {31'd0, s_req}, 32'd1);
            chk("hold_addr", s_addr, 32'h10);
        end

        step(0, 1, 32'h0000_0102, 0, 0, 0, 0);
        chk("redir_flush", {31'd0, s_flush}, 32'd1);
        step(0, 0, 0, 0, 1, 32'hDEAD_BEEF, 0);
        chk("drain_valid", {31'd0, s_vld}, 32'd0);
        chk("drain_req", {31'd0, s_req}, 32'd0);
        step(0, 0, 0, 0, 0, 0, 0);
        chk("post_drain_valid", {31'd0, s_vld}, 32'd0);
        chk("post_drain_addr", s_addr, 32'h100);
        chk("post_drain_req", {31'd0, s_req}, 32'd1);
        step(0, 0, 0, 1, 0, 0, 0);

        step(0, 1, 32'h0000_0040, 0, 1, 32'hCAFE_F00D, 0);
        step(0, 0, 0, 0, 0, 0, 0);
        chk("rv_redir_req", {31'd0, s_req}, 32'd1);
        chk("rv_redir_addr", s_addr, 32'h40);
        chk("rv_redir_valid", {31'd0, s_vld}, 32'd0);
        step(0, 0, 0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 1, 32'h0040_0113, 0);
        step(1, 1, 32'hFFFF_FFFF, 0, 0, 0, 0);
        chk("fetch40_ipc", s_ipc, 32'h40);
        chk("fetch40_instr", s_instr, 32'h0040_0113);
        chk("fetch40_addr", s_addr, 32'h44);
        step(0, 0, 0, 1, 0, 0, 0);
        chk("wrap_addr", s_addr, 32'hFFFF_FFFC);
        step(0, 0, 0, 0, 1, 32'h0000_0073, 0);
        step(1, 0, 0, 0, 0, 0, 0);
        chk("wrap_ipc", s_ipc, 32'hFFFF_FFFC);
        chk("wrap_next", s_addr, 32'h0);

        step(0, 0, 0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1, 32'hBAD0_BAD0, 1);
        chk("wrst_req", {31'd0, s_req}, 32'd0);
        chk("wrst_valid", {31'd0, s_vld}, 32'd0);
        chk("wrst_instr", s_instr, 32'h0000_0013);
        chk("wrst_addr", s_addr, 32'h0);
        step(0, 0, 0, 0, 0, 0, 0);
        chk("wrst_idle_req", {31'd0, s_req}, 32'd0);
        step(0, 0, 0, 0, 0, 0, 0);
        chk("wrst_restart_req", {31'd0, s_req}, 32'd1);
        chk("wrst_restart_valid", {31'd0, s_vld}, 32'd0);

        mem_pend = 0;
        mem_cnt  = 0;
        for (int c = 0; c < 3000; c++) begin
            logic s, r, g, rv, rs;
            logic [31:0] tgt, rd;
            rs  = ($urandom_range(0, 299) == 0);
            s   = ($urandom_range(0, 3) == 0);
            r   = ($urandom_range(0, 11) == 0);
            tgt = $urandom;
            g   = $urandom_range(0, 1);
            rv  = mem_pend && (mem_cnt == 0);
            rd  = $urandom;
            step(s, r, tgt, g, rv, rd, rs);
            if (rs) begin
                mem_pend = 0;
            end else if (rv) begin
                mem_pend = 0;
            end else if (mem_pend) begin
                mem_cnt--;
            end else if (e_req && g) begin
                mem_pend = 1;
                mem_cnt  = $urandom_range(0, 3);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
